// File: rtl/cv32e40p_apu_shared_arbiter.sv
// cv32e40p_apu_shared_arbiter
//   Shares a single APU/FPU between NUM_CORES cv32e40p cores. Requests are
//   arbitrated round-robin, the winner's operands/op/flags go to the APU, and
//   the granted core ID is queued in an in-order tag FIFO so that each APU
//   result is routed back to the core that issued it.
//
// Ports
//   clk_i, rst_i             clock, asynchronous active-high reset
//   core_apu_*_i / *_o       per-core request side (req/gnt, payload, rvalid)
//   core_apu_rdata_o/rflags  result broadcast to all cores
//   apu_*                    single shared APU port
//   busy_o                   ops in flight
//   err_unexp_rvalid_o       sticky: APU result arrived with nothing in flight
//   stats_grant_cnt_o        per-core saturating grant counters
//
// Optional feature: define CV32E40P_APU_ARB_STATS_EN to build the grant
// counters; otherwise stats_grant_cnt_o is tied to 0.
//
// While rst_i is held every output is forced to 0, including the
// combinational pass-through paths.

// Per-core slice: grant/rvalid decode and AND-masked payload for the OR mux.
module cv32e40p_apu_shared_arbiter_lane #(
  parameter int APU_NARGS    = 3,
  parameter int APU_WOP      = 6,
  parameter int APU_NDSFLAGS = 15
) (
  input  logic                    sel_hit,
  input  logic                    head_hit,
  input  logic                    push,
  input  logic                    pop,
  input  logic [APU_NARGS*32-1:0] operands,
  input  logic [APU_WOP-1:0]      op,
  input  logic [APU_NDSFLAGS-1:0] flags,
  output logic                    gnt,
  output logic                    rvalid,
  output logic [APU_NARGS*32-1:0] operands_m,
  output logic [APU_WOP-1:0]      op_m,
  output logic [APU_NDSFLAGS-1:0] flags_m
);
  assign gnt        = sel_hit & push;
  assign rvalid     = head_hit & pop;
  assign operands_m = sel_hit ? operands : '0;
  assign op_m       = sel_hit ? op : '0;
  assign flags_m    = sel_hit ? flags : '0;
endmodule

module cv32e40p_apu_shared_arbiter #(
  parameter int NUM_CORES       = 2,
  parameter int APU_NARGS       = 3,
  parameter int APU_WOP         = 6,
  parameter int APU_NDSFLAGS    = 15,
  parameter int APU_NUSFLAGS    = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NUM_CORES-1:0]                  core_apu_req_i,
  output logic [NUM_CORES-1:0]                  core_apu_gnt_o,
  input  logic [NUM_CORES*APU_NARGS*32-1:0]     core_apu_operands_i,
  input  logic [NUM_CORES*APU_WOP-1:0]          core_apu_op_i,
  input  logic [NUM_CORES*APU_NDSFLAGS-1:0]     core_apu_flags_i,
  output logic [NUM_CORES-1:0]                  core_apu_rvalid_o,
  output logic [31:0]                           core_apu_rdata_o,
  output logic [APU_NUSFLAGS-1:0]               core_apu_rflags_o,
  output logic                                  apu_req_o,
  input  logic                                  apu_gnt_i,
  output logic [APU_NARGS*32-1:0]               apu_operands_o,
  output logic [APU_WOP-1:0]                    apu_op_o,
  output logic [APU_NDSFLAGS-1:0]               apu_flags_o,
  input  logic                                  apu_rvalid_i,
  input  logic [31:0]                           apu_rdata_i,
  input  logic [APU_NUSFLAGS-1:0]               apu_rflags_i,
  output logic                                  busy_o,
  output logic                                  err_unexp_rvalid_o,
  output logic [NUM_CORES*32-1:0]               stats_grant_cnt_o
);
  localparam int CW  = $clog2(NUM_CORES);
  localparam int AW  = $clog2(MAX_OUTSTANDING);
  localparam int OPW = APU_NARGS*32;

  logic [CW-1:0] rr_ptr, sel;
  logic          any_req, active, push, pop, full, empty;

  logic [CW-1:0] tags [MAX_OUTSTANDING];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic [CW-1:0] head;
  logic          err;

  // Round-robin pick: walk backwards from rr_ptr+N-1 down to rr_ptr so the
  // last hit (the one nearest rr_ptr) wins.
  always_comb begin
    int idx;
    logic [CW-1:0] cand;
    sel     = '0;
    any_req = 1'b0;
    for (int k = NUM_CORES-1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      cand = CW'(idx);
      if (core_apu_req_i[cand]) begin
        sel     = cand;
        any_req = 1'b1;
      end
    end
  end

  assign full   = (cnt == (AW+1)'(MAX_OUTSTANDING));
  assign empty  = (cnt == '0);
  assign active = any_req & ~rst_i;
  // No bypass when full: a pop in the same cycle does not free a slot yet.
  assign apu_req_o = active & ~full;
  assign push      = apu_req_o & apu_gnt_i;
  assign pop       = apu_rvalid_i & ~empty & ~rst_i;
  assign head      = tags[rd_ptr];
  assign busy_o    = ~empty;
  assign err_unexp_rvalid_o = err;

  assign core_apu_rdata_o  = rst_i ? '0 : apu_rdata_i;
  assign core_apu_rflags_o = rst_i ? '0 : apu_rflags_i;

  // Per-core lanes
  logic [NUM_CORES-1:0][OPW-1:0]          lane_ops;
  logic [NUM_CORES-1:0][APU_WOP-1:0]      lane_op;
  logic [NUM_CORES-1:0][APU_NDSFLAGS-1:0] lane_flags;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
    cv32e40p_apu_shared_arbiter_lane #(
      .APU_NARGS   (APU_NARGS),
      .APU_WOP     (APU_WOP),
      .APU_NDSFLAGS(APU_NDSFLAGS)
    ) u_lane (
      .sel_hit   (active && (sel == CW'(i))),
      .head_hit  (head == CW'(i)),
      .push      (push),
      .pop       (pop),
      .operands  (core_apu_operands_i[i*OPW +: OPW]),
      .op        (core_apu_op_i[i*APU_WOP +: APU_WOP]),
      .flags     (core_apu_flags_i[i*APU_NDSFLAGS +: APU_NDSFLAGS]),
      .gnt       (core_apu_gnt_o[i]),
      .rvalid    (core_apu_rvalid_o[i]),
      .operands_m(lane_ops[i]),
      .op_m      (lane_op[i]),
      .flags_m   (lane_flags[i])
    );
  end

  // At most one lane is selected, so OR-ing the masked payloads is the mux.
  always_comb begin
    apu_operands_o = '0;
    apu_op_o       = '0;
    apu_flags_o    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      apu_operands_o = apu_operands_o | lane_ops[i];
      apu_op_o       = apu_op_o | lane_op[i];
      apu_flags_o    = apu_flags_o | lane_flags[i];
    end
  end

  // Arbitration pointer, tag FIFO and error flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err    <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) tags[i] <= '0;
    end else begin
      if (push) begin
        tags[wr_ptr] <= sel;
        wr_ptr       <= wr_ptr + 1'b1;
        rr_ptr       <= (sel == CW'(NUM_CORES-1)) ? '0 : sel + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (!push && pop) cnt <= cnt - 1'b1;
      if (apu_rvalid_i && empty) err <= 1'b1;
    end
  end

`ifdef CV32E40P_APU_ARB_STATS_EN
  logic [NUM_CORES-1:0][31:0] stats;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stats <= '0;
    end else begin
      for (int i = 0; i < NUM_CORES; i++)
        if (push && (sel == CW'(i)) && (stats[i] != 32'hFFFF_FFFF))
          stats[i] <= stats[i] + 32'd1;
    end
  end

  assign stats_grant_cnt_o = stats;
`else
  assign stats_grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_apu_shared_arbiter.sv
module tb_cv32e40p_apu_shared_arbiter;
  localparam int N    = 2;
  localparam int NA   = 3;
  localparam int WOP  = 6;
  localparam int NDS  = 15;
  localparam int NUS  = 5;
  localparam int MAXO = 4;
  localparam int OPW  = NA*32;

  logic                clk = 1'b0;
  logic                rst_i = 1'b1;
  logic [N-1:0]        core_apu_req_i = '0;
  logic [N-1:0]        core_apu_gnt_o;
  logic [N*OPW-1:0]    core_apu_operands_i = '0;
  logic [N*WOP-1:0]    core_apu_op_i = '0;
  logic [N*NDS-1:0]    core_apu_flags_i = '0;
  logic [N-1:0]        core_apu_rvalid_o;
  logic [31:0]         core_apu_rdata_o;
  logic [NUS-1:0]      core_apu_rflags_o;
  logic                apu_req_o;
  logic                apu_gnt_i = 1'b0;
  logic [OPW-1:0]      apu_operands_o;
  logic [WOP-1:0]      apu_op_o;
  logic [NDS-1:0]      apu_flags_o;
  logic                apu_rvalid_i = 1'b0;
  logic [31:0]         apu_rdata_i = '0;
  logic [NUS-1:0]      apu_rflags_i = '0;
  logic                busy_o;
  logic                err_unexp_rvalid_o;
  logic [N*32-1:0]     stats_grant_cnt_o;

  always #5 clk = ~clk;

  cv32e40p_apu_shared_arbiter #(
    .NUM_CORES(N), .APU_NARGS(NA), .APU_WOP(WOP), .APU_NDSFLAGS(NDS),
    .APU_NUSFLAGS(NUS), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .core_apu_req_i(core_apu_req_i), .core_apu_gnt_o(core_apu_gnt_o),
    .core_apu_operands_i(core_apu_operands_i), .core_apu_op_i(core_apu_op_i),
    .core_apu_flags_i(core_apu_flags_i), .core_apu_rvalid_o(core_apu_rvalid_o),
    .core_apu_rdata_o(core_apu_rdata_o), .core_apu_rflags_o(core_apu_rflags_o),
    .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i),
    .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o),
    .apu_rvalid_i(apu_rvalid_i), .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i),
    .busy_o(busy_o), .err_unexp_rvalid_o(err_unexp_rvalid_o),
    .stats_grant_cnt_o(stats_grant_cnt_o)
  );

  typedef struct {
    logic           apu_req;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rvalid;
    logic [OPW-1:0] ops;
    logic [WOP-1:0] op;
    logic [NDS-1:0] flags;
    logic [31:0]    rdata;
    logic [NUS-1:0] rflags;
    logic           busy;
    logic           err;
    logic [N*32-1:0] stats;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: next core in line, in-flight core IDs, error flag.
  int   rr = 0;
  int   inflight[$];
  bit   err_m = 1'b0;
  longint gcnt[N];

  // Per-core payload, held while a core's request is pending.
  logic [OPW-1:0] pay_ops[N];
  logic [WOP-1:0] pay_op[N];
  logic [NDS-1:0] pay_flags[N];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per driven cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("apu_req", apu_req_o, e.apu_req);
        chk("core_gnt", core_apu_gnt_o, e.gnt);
        chk("core_rvalid", core_apu_rvalid_o, e.rvalid);
        chk("apu_operands", apu_operands_o, e.ops);
        chk("apu_op_flags", {apu_op_o, apu_flags_o}, {e.op, e.flags});
        chk("rdata_rflags", {core_apu_rdata_o, core_apu_rflags_o}, {e.rdata, e.rflags});
        chk("busy", busy_o, e.busy);
        chk("err_unexp", err_unexp_rvalid_o, e.err);
        chk("stats", stats_grant_cnt_o, e.stats);
      end
    end
  end

  // Drive one cycle of stimulus, record what the rules predict, advance model.
  task automatic step(input logic [N-1:0] req, input bit g, input bit rv,
                      input bit rs, output logic [N-1:0] granted);
    exp_t e;
    int   sel;
    bit   anyr, full;
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      if (!req[c] || !core_apu_req_i[c]) begin
        pay_ops[c]   = {$urandom, $urandom, $urandom};
        pay_op[c]    = WOP'($urandom);
        pay_flags[c] = NDS'($urandom);
      end
      core_apu_operands_i[c*OPW +: OPW] = pay_ops[c];
      core_apu_op_i[c*WOP +: WOP]       = pay_op[c];
      core_apu_flags_i[c*NDS +: NDS]    = pay_flags[c];
    end
    rst_i          = rs;
    core_apu_req_i = req;
    apu_gnt_i      = g;
    apu_rvalid_i   = rv;
    apu_rdata_i    = $urandom;
    apu_rflags_i   = NUS'($urandom);

    anyr = (req != '0);
    sel  = 0;
    for (int k = 0; k < N; k++)
      if (req[(rr + k) % N]) begin sel = (rr + k) % N; break; end
    full = (inflight.size() == MAXO);

    e = '{default: '0};
    if (!rs) begin
      e.apu_req = anyr && !full;
      if (anyr) begin
        e.ops = pay_ops[sel]; e.op = pay_op[sel]; e.flags = pay_flags[sel];
      end
      if (e.apu_req && g) e.gnt[sel] = 1'b1;
      if (rv && inflight.size() > 0) e.rvalid[inflight[0]] = 1'b1;
      e.rdata  = apu_rdata_i;
      e.rflags = apu_rflags_i;
      e.busy   = inflight.size() != 0;
      e.err    = err_m;
`ifdef CV32E40P_APU_ARB_STATS_EN
      for (int c = 0; c < N; c++) e.stats[c*32 +: 32] = gcnt[c][31:0];
`endif
    end
    exp_q.push_back(e);
    granted = e.gnt;

    if (rs) begin
      inflight.delete();
      rr    = 0;
      err_m = 1'b0;
      for (int c = 0; c < N; c++) gcnt[c] = 0;
    end else begin
      if (rv) begin
        if (inflight.size() > 0) void'(inflight.pop_front());
        else err_m = 1'b1;
      end
      if (e.apu_req && g) begin
        inflight.push_back(sel);
        rr = (sel + 1) % N;
        if (gcnt[sel] < 64'hFFFF_FFFF) gcnt[sel]++;
      end
    end
  endtask

  task automatic drain();
    logic [N-1:0] gr;
    for (int i = 0; i < MAXO + 1 && inflight.size() > 0; i++) step('0, 1'b0, 1'b1, 1'b0, gr);
  endtask

  initial begin
    logic [N-1:0] gr;
    logic [N-1:0] pend;
    for (int c = 0; c < N; c++) gcnt[c] = 0;

    // Reset held, with a request present: everything must read 0.
    step('0, 1'b0, 1'b0, 1'b1, gr);
    step(2'b11, 1'b1, 1'b1, 1'b1, gr);
    step('0, 1'b0, 1'b0, 1'b0, gr);

    // Both cores requesting continuously, results two cycles behind grants.
    for (int i = 0; i < 10; i++) step(2'b11, 1'b1, i >= 2, 1'b0, gr);
    drain();

    // Only core 1 requests: granted every cycle.
    for (int i = 0; i < 3; i++) step(2'b10, 1'b1, 1'b0, 1'b0, gr);
    drain();

    // Fill the tag FIFO, then pop-with-request gives no grant that cycle.
    for (int i = 0; i < 5; i++) step(2'b01, 1'b1, 1'b0, 1'b0, gr);
    step(2'b01, 1'b1, 1'b1, 1'b0, gr);
    step(2'b01, 1'b1, 1'b0, 1'b0, gr);
    drain();

    // Randomized traffic with cores holding requests until granted.
    pend = '0;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < N; c++) if (!pend[c] && ($urandom % 2 == 1)) pend[c] = 1'b1;
      step(pend, ($urandom % 4) != 0, (inflight.size() > 0) && ($urandom % 3 == 0), 1'b0, gr);
      pend = pend & ~gr;
    end
    drain();

    // Reset with three ops in flight, then a stale result raises the error.
    for (int i = 0; i < 3; i++) step(2'b01, 1'b1, 1'b0, 1'b0, gr);
    step(2'b01, 1'b1, 1'b1, 1'b1, gr);
    step('0, 1'b0, 1'b1, 1'b0, gr);
    for (int i = 0; i < 3; i++) step(2'b11, 1'b1, 1'b0, 1'b0, gr);
    drain();
    step('0, 1'b0, 1'b0, 1'b1, gr);
    step('0, 1'b0, 1'b0, 1'b0, gr);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 256'(exp_q.size()), 256'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
